mac_requant: RTL and testbench

- Downstream stage of mac_unit.
- Takes signed 32-bit accumulator results and requantizes them to signed int8 activations for the next layer.
- Processing order: fixed-point multiply, rounding right shift, zero-point add, optional ReLU, saturating clamp.
- 3-stage pipeline with valid/ready handshakes on both sides, plus a saturation event counter for quantization debugging.

---
 rtl/mac_requant.sv | 174 +++++++++++++++++
 tb/tb_mac_requant.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
// Purpose : requantize signed accumulator results to signed OUT_WIDTH activations
//           (Q15 multiply, round-half-up right shift, zero-point add, optional ReLU, clamp).
// Latency : 3 cycles from input transfer to out_valid; throughput 1 item/cycle.
// Backpressure: the whole pipeline stalls together while out_valid && !out_ready.
//               Bubbles are held in place, and in_ready follows the stall.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   acc_in, in_valid,   accumulator input handshake
//   in_ready
//   mult, shift,        per-item requant config, captured together with acc_in
//   zero_point, relu_en
//   out_data,           requantized output handshake
//   out_valid, out_ready
//   sat_count,          count of items clamped by the int range (sticky at max)
//   sat_clear           clears sat_count on the next cycle
module mac_requant #(
    parameter int ACC_WIDTH  = 32,
    parameter int MULT_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [MULT_WIDTH-1:0] mult,
    input  logic        [4:0]            shift,
    input  logic signed [OUT_WIDTH-1:0]  zero_point,
    input  logic                         relu_en,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [CNT_WIDTH-1:0]  sat_count,
    input  logic                         sat_clear
);

    // Product, rounded product (one guard bit for the rounding add) and
    // zero-point sum (one more bit so the add can never wrap).
    localparam int PROD_W = ACC_WIDTH + MULT_WIDTH;
    localparam int RND_W  = PROD_W + 1;
    localparam int SUM_W  = PROD_W + 2;

    localparam logic signed [SUM_W-1:0] HI_LIM = SUM_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] LO_LIM = SUM_W'(-(2 ** (OUT_WIDTH - 1)));
    localparam logic        [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Single global advance: every stage moves together or not at all.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    // ------------------------------------------------------------------
    // Stage 1: full-width signed product, config travels alongside.
    // ------------------------------------------------------------------
    logic                        s1_vld;
    logic signed [PROD_W-1:0]    s1_prod;
    logic        [4:0]           s1_shift;
    logic signed [OUT_WIDTH-1:0] s1_zp;
    logic                        s1_relu;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
            s1_relu  <= 1'b0;
        end else if (advance) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_prod  <= PROD_W'(acc_in) * PROD_W'(mult);
                s1_shift <= shift;
                s1_zp    <= zero_point;
                s1_relu  <= relu_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rounding arithmetic shift. Adding half an LSB and then
    // flooring gives round-half-toward-+inf for both signs. With shift=0
    // the bias is zero and the shift is a no-op, so one path covers both.
    // ------------------------------------------------------------------
    logic signed [RND_W-1:0] rnd_bias;
    logic signed [RND_W-1:0] rnd_sum;
    logic signed [RND_W-1:0] rnd_res;

    always_comb begin
        rnd_bias = '0;
        if (s1_shift != 5'd0) begin
            rnd_bias = RND_W'(1) << (s1_shift - 5'd1);
        end
        rnd_sum = {s1_prod[PROD_W-1], s1_prod} + rnd_bias;
        rnd_res = rnd_sum >>> s1_shift;
    end

    logic                        s2_vld;
    logic signed [RND_W-1:0]     s2_r;
    logic signed [OUT_WIDTH-1:0] s2_zp;
    logic                        s2_relu;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_r    <= '0;
            s2_zp   <= '0;
            s2_relu <= 1'b0;
        end else if (advance) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_r    <= rnd_res;
                s2_zp   <= s1_zp;
                s2_relu <= s1_relu;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: zero-point add, ReLU-aware lower bound, clamp.
    // Only leaving the int range counts as saturation. Being pulled up to
    // the ReLU floor is intended behaviour, so it is not counted.
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0]     zp_sum;
    logic signed [SUM_W-1:0]     lo_lim;
    logic signed [OUT_WIDTH-1:0] clamp_val;
    logic                        sat_evt;

    always_comb begin
        zp_sum = {s2_r[RND_W-1], s2_r}
               + {{(SUM_W - OUT_WIDTH){s2_zp[OUT_WIDTH-1]}}, s2_zp};
        lo_lim = s2_relu ? {{(SUM_W - OUT_WIDTH){s2_zp[OUT_WIDTH-1]}}, s2_zp} : LO_LIM;
        sat_evt = (zp_sum > HI_LIM) || (zp_sum < LO_LIM);

        clamp_val = zp_sum[OUT_WIDTH-1:0];
        if (zp_sum > HI_LIM) begin
            clamp_val = HI_LIM[OUT_WIDTH-1:0];
        end else if (zp_sum < lo_lim) begin
            clamp_val = lo_lim[OUT_WIDTH-1:0];
        end
    end

    // Output register. It holds while stalled because advance=0 then.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_data <= clamp_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturation counter. Counting is tied to the stage-3 load, which
    // happens exactly once per item. An item parked in the output register
    // under stall is therefore never recounted. Clear wins over a
    // coincident event.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (advance && s2_vld && sat_evt && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Purpose : directed self-checking bench for mac_requant.
// Latency : checks the 3-cycle transfer-to-out_valid latency and in-order delivery.
// Backpressure: drives an out_ready stall window and checks that the output is held.
module tb_mac_requant;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [31:0] acc_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] mult;
    logic        [4:0]  shift;
    logic signed [7:0]  zero_point;
    logic              relu_en;
    logic signed [7:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic        [15:0] sat_count;
    logic              sat_clear;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_requant #(
        .ACC_WIDTH (32),
        .MULT_WIDTH(16),
        .OUT_WIDTH (8),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mult      (mult),
        .shift     (shift),
        .zero_point(zero_point),
        .relu_en   (relu_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_count (sat_count),
        .sat_clear (sat_clear)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int acc, input int mlt, input int sh, input int zp, input bit relu);
        acc_in     = acc;
        mult       = 16'(mlt);
        shift      = 5'(sh);
        zero_point = 8'(zp);
        relu_en    = relu;
    endtask

    // Send one item into an idle pipeline, measure its latency and check the result.
    task automatic run_one(input string tag, input int acc, input int mlt, input int sh,
                           input int zp, input bit relu, input int exp_out, input int exp_sat);
        int cyc;
        set_cfg(acc, mlt, sh, zp, relu);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_out"}, int'(out_data), exp_out);
        check({tag, "_sat"}, int'(sat_count), exp_sat);
        tick();
    endtask

    initial begin
        int exp_q[$];
        int sent;
        int got;
        int cyc;
        int stale;
        bit prev_stall;
        logic signed [7:0] held;

        rst = 1'b1;
        sat_clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // Rounding, sign, ReLU and zero point
        run_one("round_7p5", 15, 16384, 15, 0, 1'b0, 8, 0);
        run_one("neg", -50, 16384, 15, 0, 1'b0, -25, 0);
        run_one("relu", -50, 16384, 15, 0, 1'b1, 0, 0);
        run_one("zp_neg", 15, 16384, 15, -5, 1'b0, 3, 0);
        run_one("relu_zp_neg", -100, 1, 0, -5, 1'b1, -5, 0);
        run_one("half_neg", -1, 1, 1, 0, 1'b0, 0, 0);
        run_one("half_pos", 1, 1, 1, 0, 1'b0, 1, 0);
        run_one("shift31", 1073741824, 2, 31, 0, 1'b0, 1, 0);
        run_one("edge_hi", 127, 1, 0, 0, 1'b0, 127, 0);
        run_one("edge_lo", -128, 1, 0, 0, 1'b0, -128, 0);

        // Saturation and clear
        run_one("sat_hi", 16129, 32767, 15, 0, 1'b0, 127, 1);
        run_one("sat_lo", -200, 1, 0, 0, 1'b0, -128, 2);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("sat_clear", int'(sat_count), 0);

        // Backpressure stream 1..6 (x*16384 >> 14 == x)
        set_cfg(0, 16384, 14, 0, 1'b0);
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (sent < 6);
            acc_in    = sent + 1;
            #1;
            if (out_valid && !out_ready) begin
                check("bp_in_ready", int'(in_ready), 0);
                if (prev_stall) check("bp_hold", int'(out_data), int'(held));
                held = out_data;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                exp_q.push_back(got + 1);
                check("bp_order", int'(out_data), exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got, 6);
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) stale++;
            tick();
        end
        check("bp_no_dup", stale, 0);

        // Config is carried with the data: shift 15 then 0
        set_cfg(100, 16384, 15, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        shift = 5'd0;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("cfg_first", int'(out_data), 50);
        tick();
        check("cfg_second_vld", int'(out_valid), 1);
        check("cfg_second", int'(out_data), 127);
        check("cfg_sat", int'(sat_count), 1);
        tick();

        // Clear coinciding with a saturation event: clear wins
        set_cfg(-200, 1, 0, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("clr_win_vld", int'(out_valid), 1);
        check("clr_win_out", int'(out_data), -128);
        check("clr_win_cnt", int'(sat_count), 0);
        tick();

        // Reset with three items in flight
        set_cfg(500, 1, 0, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        acc_in = 600;
        tick();
        acc_in = 700;
        tick();
        in_valid = 1'b0;
        check("mid_sat_before", int'(sat_count), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        check("mid_rst_vld", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_sat", int'(sat_count), 0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", int'(in_ready), 1);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) stale++;
        end
        check("mid_rst_no_stale", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
